// File: rtl/vehicle_pkg.sv
// Shared vehicle encodings and the mode-selection rule.
//   turn_state_t : turn indicator lever encoding (10 is an unused code, treated as none)
//   gear_state_t : gear selector encoding
//   lamp_mode_t  : lamp scheduler operating mode, also visible on the _mode port
//   select_mode  : hazard wins, then the turn lever (only with ignition on), else idle
package vehicle_pkg;

  typedef enum logic [1:0] {
    TURN_NONE    = 2'b00,
    TURN_LEFT    = 2'b01,
    TURN_INVALID = 2'b10,
    TURN_RIGHT   = 2'b11
  } turn_state_t;

  typedef enum logic [1:0] {
    GEAR_LOCK    = 2'b00,
    GEAR_PARKING = 2'b01,
    GEAR_REVERSE = 2'b10,
    GEAR_FORWARD = 2'b11
  } gear_state_t;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_HAZARD = 2'b10,
    MODE_RIGHT  = 2'b11
  } lamp_mode_t;

  localparam logic [7:0] FLASH_MAX = 8'hFF;

  function automatic lamp_mode_t select_mode(input logic        hazard,
                                             input logic        ignition,
                                             input turn_state_t turn);
    lamp_mode_t m;
    m = MODE_IDLE;
    if (hazard) begin
      m = MODE_HAZARD;
    end else if (ignition && turn == TURN_LEFT) begin
      m = MODE_LEFT;
    end else if (ignition && turn == TURN_RIGHT) begin
      m = MODE_RIGHT;
    end
    return m;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator: counts 0..BLINK_HALF-1 and toggles the lamp phase
// at each terminal count.
//   clock    : rising-edge clock
//   _reset   : synchronous active-high reset (counter 0, phase off)
//   restart  : begin a fresh on-phase with the counter at 0
//   enable   : 0 holds counter and phase at 0 (idle); dominates restart
//   phase    : registered lamp phase, 1 = on
//   on_start : high in the cycle whose edge starts an on-phase (restart or
//              off->on toggle), so the caller can count flashes on that edge
module blink_timer #(
  parameter int BLINK_HALF = 4
) (
  input  logic clock,
  input  logic _reset,
  input  logic restart,
  input  logic enable,
  output logic phase,
  output logic on_start
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(BLINK_HALF - 1);

  logic [CW-1:0] count_q, count_d;
  logic          phase_q, phase_d;

  always_comb begin
    count_d  = count_q;
    phase_d  = phase_q;
    on_start = 1'b0;
    if (!enable) begin
      count_d = '0;
      phase_d = 1'b0;
    end else if (restart) begin
      count_d  = '0;
      phase_d  = 1'b1;
      on_start = 1'b1;
    end else if (count_q == TERMINAL) begin
      count_d  = '0;
      phase_d  = ~phase_q;
      on_start = ~phase_q;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (_reset) begin
      count_q <= '0;
      phase_q <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/lamp_scheduler.sv
// Vehicle lamp scheduler: turn indicators, hazard flasher, brake and reverse lamps.
//   clock        : rising-edge clock
//   _reset       : synchronous active-high reset
//   _switch      : ignition, 1 = on
//   _turnState   : turn lever (00 none, 01 left, 11 right, 10 none)
//   _gearState   : gear (00 lock, 01 parking, 10 reverse, 11 forward)
//   _hazardReq   : hazard button level; each rising edge toggles hazard
//   _brakePedal  : brake pedal pressed
//   _leftLamp/_rightLamp     : indicator lamp drives
//   _brakeLamp/_reverseLamp  : brake and reverse lamp drives
//   _mode        : operating mode (00 IDLE, 01 LEFT, 11 RIGHT, 10 HAZARD)
//   _flashCount  : on-phases started since mode entry, saturating at 255
// Every output is a register or a gate of registers only, so inputs sampled
// at one edge appear at the outputs right after that edge.
module lamp_scheduler
  import vehicle_pkg::*;
#(
  parameter int BLINK_HALF = 4
) (
  input  logic       clock,
  input  logic       _reset,
  input  logic       _switch,
  input  logic [1:0] _turnState,
  input  logic [1:0] _gearState,
  input  logic       _hazardReq,
  input  logic       _brakePedal,
  output logic       _leftLamp,
  output logic       _rightLamp,
  output logic       _brakeLamp,
  output logic       _reverseLamp,
  output logic [1:0] _mode,
  output logic [7:0] _flashCount
);

  // Previous button sample resets high: a button held through reset must
  // not look like a fresh press on release.
  logic       hz_prev_q;
  logic       hazard_q, hazard_d;
  lamp_mode_t mode_q, mode_d;
  logic [7:0] flash_q, flash_d;
  logic       brake_q, reverse_q;
  logic       restart, enable, phase, on_start;

  // Mode FSM, next-state side. The new hazard value is used so a press takes
  // effect on the same edge that samples it, and a hazard toggle coinciding
  // with a lever change resolves to one mode with one restart.
  always_comb begin
    hazard_d = hazard_q ^ (_hazardReq & ~hz_prev_q);
    mode_d   = select_mode(hazard_d, _switch, turn_state_t'(_turnState));
    restart  = (mode_d != mode_q);
    enable   = (mode_d != MODE_IDLE);
  end

  always_ff @(posedge clock) begin
    if (_reset) begin
      mode_q <= MODE_IDLE;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_ff @(posedge clock) begin
    if (_reset) begin
      hz_prev_q <= 1'b1;
      hazard_q  <= 1'b0;
      brake_q   <= 1'b0;
      reverse_q <= 1'b0;
    end else begin
      hz_prev_q <= _hazardReq;
      hazard_q  <= hazard_d;
      brake_q   <= _brakePedal;
      reverse_q <= _switch && (gear_state_t'(_gearState) == GEAR_REVERSE);
    end
  end

  blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink_timer (
    .clock    (clock),
    ._reset   (_reset),
    .restart  (restart),
    .enable   (enable),
    .phase    (phase),
    .on_start (on_start)
  );

  // Restart loads 1 (the restart itself is the first on-phase); later
  // off->on toggles add one until saturation.
  always_comb begin
    flash_d = flash_q;
    if (!enable) begin
      flash_d = 8'd0;
    end else if (restart) begin
      flash_d = 8'd1;
    end else if (on_start && flash_q != FLASH_MAX) begin
      flash_d = flash_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (_reset) begin
      flash_q <= 8'd0;
    end else begin
      flash_q <= flash_d;
    end
  end

  assign _leftLamp    = phase & ((mode_q == MODE_LEFT)  || (mode_q == MODE_HAZARD));
  assign _rightLamp   = phase & ((mode_q == MODE_RIGHT) || (mode_q == MODE_HAZARD));
  assign _brakeLamp   = brake_q;
  assign _reverseLamp = reverse_q;
  assign _mode        = mode_q;
  assign _flashCount  = flash_q;

endmodule

// File: tb/tb_lamp_scheduler.sv
// Bench for lamp_scheduler with BLINK_HALF=4. A behavioural model tracks the
// number of cycles spent in the current mode and derives phase and flash count
// from it; each step pushes the model's expected outputs and pops/compares
// them one edge later. Directed checks add spot values for key scenarios.
module tb_lamp_scheduler;

  localparam int BH = 4;

  logic       clock = 1'b0;
  logic       _reset = 1'b1;
  logic       _switch = 1'b0;
  logic [1:0] _turnState = 2'b00;
  logic [1:0] _gearState = 2'b00;
  logic       _hazardReq = 1'b0;
  logic       _brakePedal = 1'b0;
  logic       _leftLamp, _rightLamp, _brakeLamp, _reverseLamp;
  logic [1:0] _mode;
  logic [7:0] _flashCount;

  lamp_scheduler #(.BLINK_HALF(BH)) dut (
    .clock        (clock),
    ._reset       (_reset),
    ._switch      (_switch),
    ._turnState   (_turnState),
    ._gearState   (_gearState),
    ._hazardReq   (_hazardReq),
    ._brakePedal  (_brakePedal),
    ._leftLamp    (_leftLamp),
    ._rightLamp   (_rightLamp),
    ._brakeLamp   (_brakeLamp),
    ._reverseLamp (_reverseLamp),
    ._mode        (_mode),
    ._flashCount  (_flashCount)
  );

  // clock / reset block
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];

  // model state
  logic       m_hz_prev = 1'b1;
  logic       m_hazard = 1'b0;
  logic [1:0] m_mode = 2'b00;
  int         m_t = 0;
  logic       m_brake = 1'b0;
  logic       m_rev = 1'b0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    logic [1:0] nm;
    if (_reset) begin
      m_hz_prev = 1'b1;
      m_hazard  = 1'b0;
      m_mode    = 2'b00;
      m_t       = 0;
      m_brake   = 1'b0;
      m_rev     = 1'b0;
    end else begin
      if (_hazardReq && !m_hz_prev) m_hazard = !m_hazard;
      m_hz_prev = _hazardReq;
      if (m_hazard)                          nm = 2'b10;
      else if (_switch && _turnState == 2'b01) nm = 2'b01;
      else if (_switch && _turnState == 2'b11) nm = 2'b11;
      else                                   nm = 2'b00;
      if (nm != m_mode) m_t = 0;
      else              m_t = m_t + 1;
      m_mode  = nm;
      m_brake = _brakePedal;
      m_rev   = _switch && (_gearState == 2'b10);
    end
  endtask

  function automatic logic [13:0] model_out();
    logic       ph;
    int         fl;
    logic       l, r;
    logic [7:0] f;
    ph = ((m_t / BH) % 2) == 0;
    fl = m_t / (2 * BH) + 1;
    if (fl > 255) fl = 255;
    l = 1'b0;
    r = 1'b0;
    f = 8'd0;
    if (m_mode != 2'b00) begin
      f = fl[7:0];
      l = ph && (m_mode == 2'b01 || m_mode == 2'b10);
      r = ph && (m_mode == 2'b11 || m_mode == 2'b10);
    end
    return {l, r, m_brake, m_rev, m_mode, f};
  endfunction

  // driver: apply current inputs for one edge, scoreboard the result
  task automatic step();
    logic [13:0] obs, exp;
    model_update();
    exp_q.push_back(model_out());
    @(posedge clock);
    #1;
    obs = {_leftLamp, _rightLamp, _brakeLamp, _reverseLamp, _mode, _flashCount};
    exp = exp_q.pop_front();
    check("scoreboard", 16'(obs), 16'(exp));
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic seen_on, seen_off;

  initial begin
    // reset state
    _reset = 1'b1;
    step_n(2);
    check("reset_mode", 16'(_mode), 16'h0);
    check("reset_flash", 16'(_flashCount), 16'h0);
    check("reset_lamps", 16'({_leftLamp, _rightLamp, _brakeLamp, _reverseLamp}), 16'h0);
    _reset = 1'b0;
    step();

    // left blink 4 on / 4 off / on again
    _switch = 1'b1; _turnState = 2'b01;
    step();
    check("left_mode", 16'(_mode), 16'h1);
    check("left_first_on", 16'({_leftLamp, _rightLamp}), 16'b10);
    step_n(3);
    check("left_on_4th", 16'(_leftLamp), 16'h1);
    step();
    check("left_off", 16'(_leftLamp), 16'h0);
    step_n(4);
    check("left_second_on", 16'({_leftLamp, _flashCount}), {7'd0, 1'b1, 8'd2});

    // direct left -> right at on-phase cycle 2
    step_n(2);
    _turnState = 2'b11;
    step();
    check("right_restart", 16'({_mode, _leftLamp, _rightLamp, _flashCount}), {4'd0, 2'b11, 2'b01, 8'd1});
    step_n(5);

    // ignition off drops the turn mode; brake and reverse lamps
    _switch = 1'b0;
    step();
    check("ignition_off_idle", 16'(_mode), 16'h0);
    _switch = 1'b1; _turnState = 2'b00; _gearState = 2'b10;
    step();
    check("reverse_on", 16'(_reverseLamp), 16'h1);
    _switch = 1'b0; _brakePedal = 1'b1;
    step();
    check("brake_no_ignition", 16'({_brakeLamp, _reverseLamp}), 16'b10);
    _brakePedal = 1'b0; _gearState = 2'b00;

    // hazard with ignition off, ignition toggling has no effect, second press clears
    _hazardReq = 1'b1;
    step();
    check("hazard_on", 16'({_mode, _leftLamp, _rightLamp}), 16'b1011);
    _hazardReq = 1'b0;
    step_n(3);
    _switch = 1'b1; step_n(2);
    _switch = 1'b0; step_n(5);
    check("hazard_persist", 16'(_mode), 16'h2);
    _hazardReq = 1'b1;
    step();
    check("hazard_off", 16'({_mode, _leftLamp, _rightLamp}), 16'h0);
    _hazardReq = 1'b0;
    step();

    // hazard press coinciding with a lever change, then clear into a turn mode
    _switch = 1'b1; _turnState = 2'b11;
    step_n(3);
    _hazardReq = 1'b1; _turnState = 2'b01;
    step();
    check("hazard_with_lever", 16'({_mode, _flashCount}), {6'd0, 2'b10, 8'd1});
    step_n(5);
    _hazardReq = 1'b0; step();
    _hazardReq = 1'b1; step();
    check("hazard_clear_to_left", 16'({_mode, _leftLamp, _flashCount}), {5'd0, 2'b01, 1'b1, 8'd1});

    // button held through reset must not toggle hazard
    _switch = 1'b0; _turnState = 2'b00; _reset = 1'b1;
    step_n(2);
    _reset = 1'b0;
    step_n(3);
    check("held_through_reset", 16'(_mode), 16'h0);
    _hazardReq = 1'b0; step();
    _hazardReq = 1'b1; step();
    check("press_after_reset", 16'(_mode), 16'h2);

    // reset mid-blink aborts, release restarts cleanly
    step_n(3);
    _reset = 1'b1;
    step();
    check("mid_blink_reset", 16'({_mode, _leftLamp, _rightLamp, _flashCount}), 16'h0);
    _reset = 1'b0; _switch = 1'b1; _turnState = 2'b01;
    step();
    check("release_restart", 16'({_mode, _leftLamp, _flashCount}), {5'd0, 2'b01, 1'b1, 8'd1});

    // long hazard run: flash count saturates, lamps keep blinking
    _hazardReq = 1'b0; step();
    _hazardReq = 1'b1; step();
    step_n(2100 - 8);
    seen_on = 1'b0; seen_off = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (_leftLamp === 1'b1) seen_on = 1'b1;
      if (_leftLamp === 1'b0) seen_off = 1'b1;
    end
    check("flash_saturated", 16'(_flashCount), 16'd255);
    check("blink_after_sat", 16'({seen_on, seen_off}), 16'b11);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      _reset      = ($urandom_range(0, 49) == 0);
      _switch     = 1'($urandom_range(0, 3) != 0);
      _turnState  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : _turnState;
      _gearState  = 2'($urandom_range(0, 3));
      _hazardReq  = ($urandom_range(0, 15) == 0) ? ~_hazardReq : _hazardReq;
      _brakePedal = 1'($urandom_range(0, 1));
      step();
    end

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
